// File: rtl/div_radix2_pkg.sv
// Shared types for the radix-2 restoring divider.
package div_radix2_pkg;

    // Width of the iteration counter; covers operand widths up to 64.
    localparam int CNT_W = 6;

    // Sign fix-up flags captured when an operation is accepted.
    typedef struct packed {
        logic neg_q;
        logic neg_r;
    } sign_fix_t;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor in WIDTH+1 bits, keep the difference when it is non-negative.
module div_radix2_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // Partial remainder is always below the divisor, so WIDTH+1 bits hold the
    // shifted value and bit WIDTH of the difference is a reliable borrow flag.
    assign trial    = {rem, bit_in};
    assign diff     = trial - {1'b0, divisor};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider (signed DIV / unsigned DIVU).
// Result is {remainder, quotient}; fixed latency of WIDTH+1 cycles.
//
// Handshake: start is a one-cycle request accepted only in IDLE without
// annul; operands are sampled on that edge. busy is high while an operation
// is in flight. ready is a one-cycle pulse in DONE (suppressed by annul) and
// result is valid while ready is high, then holds until the next DONE.
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               annul,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] result,
    output logic [1:0]         state_dbg
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [2*WIDTH-1:0] rq;        // {partial remainder, dividend/quotient bits}
    logic [WIDTH-1:0]   dvs;       // |divisor|
    logic [CNT_W-1:0]   cnt;
    sign_fix_t          fix;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH-1:0]   rem_next;
    logic               q_bit;
    logic [WIDTH-1:0]   q_fixed;
    logic [WIDTH-1:0]   r_fixed;
    logic [2*WIDTH-1:0] fixed;

    // Magnitudes of the operands; the most negative value maps onto itself
    // and is then treated as unsigned.
    assign a_abs = (signed_div & dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_abs = (signed_div & divisor[WIDTH-1])  ? -divisor  : divisor;

    div_radix2_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rq[2*WIDTH-1:WIDTH]),
        .bit_in   (rq[WIDTH-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign q_fixed = fix.neg_q ? -rq[WIDTH-1:0]       : rq[WIDTH-1:0];
    assign r_fixed = fix.neg_r ? -rq[2*WIDTH-1:WIDTH] : rq[2*WIDTH-1:WIDTH];
    assign fixed   = {r_fixed, q_fixed};

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; annul returns to IDLE from anywhere.
    always_comb begin
        state_next = state;
        if (annul) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_next = S_ITER;
                S_ITER:  if (cnt == CNT_W'(WIDTH - 1)) state_next = S_DONE;
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, one shift/subtract per ITER cycle, result capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rq       <= '0;
            dvs      <= '0;
            cnt      <= '0;
            fix      <= '0;
            result_q <= '0;
        end else if (!annul) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rq        <= {{WIDTH{1'b0}}, a_abs};
                        dvs       <= b_abs;
                        cnt       <= '0;
                        fix.neg_q <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        fix.neg_r <= signed_div & dividend[WIDTH-1];
                    end
                end
                S_ITER: begin
                    rq  <= {rem_next, rq[WIDTH-2:0], q_bit};
                    cnt <= cnt + CNT_W'(1);
                end
                S_DONE: begin
                    result_q <= fixed;
                end
                default: ;
            endcase
        end
    end

    // Outputs; result is shown combinationally during the ready cycle.
    always_comb begin
        busy      = (state != S_IDLE);
        ready     = (state == S_DONE) & ~annul;
        result    = ready ? fixed : result_q;
        state_dbg = state;
    end

endmodule

// File: tb/tb_div_radix2.sv
// Directed test of div_radix2 with an expected-result queue.
module tb_div_radix2;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        busy;
    logic        ready;
    logic [63:0] result;
    logic [1:0]  state_dbg;

    logic [63:0] exp_q[$];
    logic [63:0] last_exp;
    int          total;
    int          bad;
    int          lat;

    div_radix2 #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .busy       (busy),
        .ready      (ready),
        .result     (result),
        .state_dbg  (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: magnitudes, plain / and %, divide-by-zero rule, sign fix-up.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ua, ub, q, r;
        ua = (sgn && a[31]) ? -a : a;
        ub = (sgn && b[31]) ? -b : b;
        if (ub == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start; inputs change at negedge, sampled at next posedge.
    task automatic pulse_start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start      = 1'b1;
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Issue an operation and record its expected result.
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(model(sgn, a, b));
        pulse_start(sgn, a, b);
    endtask

    // Count cycles after the start edge until ready; inj>0 fires a stray start
    // (different operands) in that cycle, which must be ignored.
    task automatic wait_ready(input int inj, output int l);
        logic [63:0] e;
        l = 0;
        for (int n = 1; n <= 40 && l == 0; n++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (n == inj) begin
                start      = 1'b1;
                signed_div = 1'b0;
                dividend   = 32'd9;
                divisor    = 32'd3;
            end
            check($sformatf("busy_c%0d", n), {63'd0, busy}, 64'd1);
            if (ready) l = n;
        end
        start = 1'b0;
        check("latency", 64'(l), 64'd33);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check("result", result, e);
        last_exp = e;
        @(negedge clk);
        check("busy_after", {63'd0, busy}, 64'd0);
        check("ready_after", {63'd0, ready}, 64'd0);
        check("hold_after", result, e);
    endtask

    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        start_op(sgn, a, b);
        wait_ready(0, lat);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        last_exp   = '0;
        resetn     = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        annul      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_state", {62'd0, state_dbg}, 64'd0);
        resetn = 1'b1;

        // Main function
        run(1'b0, 32'd100, 32'd7);
        check("udiv_100_7_const", last_exp, {32'h0000_0002, 32'h0000_000E});
        run(1'b1, 32'hFFFF_FFF9, 32'd2);
        check("sdiv_m7_2_const", last_exp, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run(1'b1, 32'd7, 32'hFFFF_FFFE);
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run(1'b0, 32'h1234_5678, 32'd0);
        check("udiv_by0_const", last_exp, {32'h1234_5678, 32'hFFFF_FFFF});
        run(1'b1, 32'hFFFF_FFF9, 32'd0);
        check("sdiv_by0_const", last_exp, {32'hFFFF_FFF9, 32'h0000_0001});
        run(1'b1, 32'd1000, 32'd0);
        for (int i = 0; i < 4; i++) begin
            run(1'(i & 1), $urandom_range(32'hFFFF_FFFF, 0), $urandom_range(32'h0000_FFFF, 1));
        end

        // Stray start mid-operation is ignored
        start_op(1'b0, 32'd100, 32'd7);
        wait_ready(5, lat);

        // Annul at cycle 10: no ready, busy drops, result held
        pulse_start(1'b0, 32'd1000, 32'd3);
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            check($sformatf("annul_ready_c%0d", n), {63'd0, ready}, 64'd0);
        end
        @(negedge clk);
        annul = 1'b1;
        check("annul_ready_c10", {63'd0, ready}, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        check("annul_busy_c11", {63'd0, busy}, 64'd0);
        check("annul_ready_c11", {63'd0, ready}, 64'd0);
        check("annul_result", result, last_exp);
        run(1'b0, 32'd9, 32'd3);
        check("after_annul_const", last_exp, {32'd0, 32'd3});

        // Start together with annul is ignored
        @(negedge clk);
        annul = 1'b1;
        pulse_start(1'b0, 32'd50, 32'd5);
        annul = 1'b0;
        @(negedge clk);
        check("start_annul_busy", {63'd0, busy}, 64'd0);

        // Reset mid-operation
        pulse_start(1'b1, 32'd500, 32'd7);
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_ready", {63'd0, ready}, 64'd0);
        check("midrst_result", result, 64'd0);
        check("midrst_state", {62'd0, state_dbg}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run(1'b0, 32'h1234_5678, 32'd17);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
